// File: rtl/kb_ascii_bridge_if.sv
// Handshake bundle between the bridge, the scan-code FIFO and the UART TX FIFO.
// slave is the bridge side; master is the surrounding environment.
interface kb_ascii_bridge_if;
  logic       kb_empty;
  logic [7:0] key_code;
  logic       kb_rd;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] wr_data;

  modport master (
    output kb_empty, key_code, tx_full,
    input  kb_rd, wr_uart, wr_data
  );

  modport slave (
    input  kb_empty, key_code, tx_full,
    output kb_rd, wr_uart, wr_data
  );
endinterface

// File: rtl/kb_ascii_bridge.sv
// Set-2 scan-code to ASCII bridge with a 2^DEPTH_LOG2 entry output FIFO.
// Define KB_CAPS_LOCK_EN to enable caps-lock tracking (make 58 toggles).
//
// state     | meaning
// IDLE      | waiting for a make code or a prefix
// BREAK     | F0 seen; next code is a key release
// EXT       | E0 seen; next code is an extended key
// EXT_BREAK | E0 F0 seen; next code is an extended release
module kb_ascii_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  kb_ascii_bridge_if.slave    bus,
  output logic                shift_active,
  output logic                caps_lock,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] fifo_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
  state_t state, state_nxt;

  logic                  take, pop, push_req, push_ok;
  logic                  shl, shr, shl_set, shl_clr, shr_set, shr_clr;
  logic                  caps_make, caps_brk;
  logic [7:0]            push_char;
  logic [8:0]            xlat;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

  function automatic logic [8:0] alpha(input logic [7:0] up, input logic upper);
    return {1'b1, upper ? up : (up | 8'h20)};
  endfunction

  function automatic logic [8:0] num(input logic [7:0] plain, input logic [7:0] shifted,
                                     input logic shift);
    return {1'b1, shift ? shifted : plain};
  endfunction

  // Bit 8 flags a translatable code; bits 7:0 hold the character.
  function automatic logic [8:0] translate(input logic [7:0] code, input logic upper,
                                           input logic shift);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h1C: r = alpha("A", upper);   8'h32: r = alpha("B", upper);
      8'h21: r = alpha("C", upper);   8'h23: r = alpha("D", upper);
      8'h24: r = alpha("E", upper);   8'h2B: r = alpha("F", upper);
      8'h34: r = alpha("G", upper);   8'h33: r = alpha("H", upper);
      8'h43: r = alpha("I", upper);   8'h3B: r = alpha("J", upper);
      8'h42: r = alpha("K", upper);   8'h4B: r = alpha("L", upper);
      8'h3A: r = alpha("M", upper);   8'h31: r = alpha("N", upper);
      8'h44: r = alpha("O", upper);   8'h4D: r = alpha("P", upper);
      8'h15: r = alpha("Q", upper);   8'h2D: r = alpha("R", upper);
      8'h1B: r = alpha("S", upper);   8'h2C: r = alpha("T", upper);
      8'h3C: r = alpha("U", upper);   8'h2A: r = alpha("V", upper);
      8'h1D: r = alpha("W", upper);   8'h22: r = alpha("X", upper);
      8'h35: r = alpha("Y", upper);   8'h1A: r = alpha("Z", upper);
      8'h45: r = num("0", ")", shift); 8'h16: r = num("1", "!", shift);
      8'h1E: r = num("2", "@", shift); 8'h26: r = num("3", "#", shift);
      8'h25: r = num("4", "$", shift); 8'h2E: r = num("5", "%", shift);
      8'h36: r = num("6", "^", shift); 8'h3D: r = num("7", "&", shift);
      8'h3E: r = num("8", "*", shift); 8'h46: r = num("9", "(", shift);
      8'h29: r = 9'h120;
      8'h5A: r = 9'h10D;
      8'h66: r = 9'h108;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign take         = !bus.kb_empty && !reset;
  assign bus.kb_rd    = take;
  assign shift_active = shl | shr;
  assign xlat         = translate(bus.key_code, shift_active ^ caps_lock, shift_active);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_char = 8'h00;
    shl_set   = 1'b0;
    shl_clr   = 1'b0;
    shr_set   = 1'b0;
    shr_clr   = 1'b0;
    caps_make = 1'b0;
    caps_brk  = 1'b0;
    if (take) begin
      case (state)
        IDLE: begin
          case (bus.key_code)
            8'hF0:   state_nxt = BREAK;
            8'hE0:   state_nxt = EXT;
            8'h12:   shl_set   = 1'b1;
            8'h59:   shr_set   = 1'b1;
            8'h58:   caps_make = 1'b1;
            default: begin
              push_req  = xlat[8];
              push_char = xlat[7:0];
            end
          endcase
        end
        BREAK: begin
          state_nxt = IDLE;
          shl_clr   = (bus.key_code == 8'h12);
          shr_clr   = (bus.key_code == 8'h59);
          caps_brk  = (bus.key_code == 8'h58);
        end
        EXT: begin
          if (bus.key_code == 8'hF0) begin
            state_nxt = EXT_BREAK;
          end else begin
            state_nxt = IDLE;
            if (bus.key_code == 8'h5A) begin
              push_req  = 1'b1;
              push_char = 8'h0D;
            end
          end
        end
        EXT_BREAK: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shl <= 1'b0;
      shr <= 1'b0;
    end else begin
      if (shl_set)      shl <= 1'b1;
      else if (shl_clr) shl <= 1'b0;
      if (shr_set)      shr <= 1'b1;
      else if (shr_clr) shr <= 1'b0;
    end
  end

`ifdef KB_CAPS_LOCK_EN
  // caps_held suppresses re-toggling on typematic repeats of the caps key.
  logic caps_held;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
    end else begin
      if (caps_make && !caps_held) caps_lock <= !caps_lock;
      if (caps_make)     caps_held <= 1'b1;
      else if (caps_brk) caps_held <= 1'b0;
    end
  end
`else
  logic caps_unused;
  assign caps_unused = caps_make ^ caps_brk;
  assign caps_lock   = 1'b0;
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop         = (fifo_count != '0) && !bus.tx_full;
  assign push_ok     = push_req && ((fifo_count < FULL_CNT) || pop);
  assign overflow    = push_req && !push_ok;
  assign bus.wr_uart = pop;
  assign bus.wr_data = (fifo_count != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_kb_ascii_bridge.sv
// Bench for kb_ascii_bridge: directed scenarios plus randomized codes, gaps and
// back-pressure, checked each cycle against a queue-based keyboard model.
module tb_kb_ascii_bridge;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
`ifdef KB_CAPS_LOCK_EN
  localparam bit CAPS_EN = 1'b1;
`else
  localparam bit CAPS_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           shift_active, caps_lock, overflow;
  logic [DL2:0]   fifo_count;

  kb_ascii_bridge_if bus();

  kb_ascii_bridge #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .shift_active (shift_active),
    .caps_lock    (caps_lock),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] seq[$];
  logic [7:0] codes[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         m_brk, m_ext, m_shl, m_shr, m_caps, m_held;
  bit         gap_en, avail;
  int         tx_mode, n_rd, n_ovf, max_cnt, loop_steps;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};
  string      shifted_digits = ")!@#$%^&*(";

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int xlate(logic [7:0] c, bit sh, bit cp);
    int r = -1;
    foreach (letter_codes[i]) if (letter_codes[i] == c) r = (sh ^ cp) ? 65 + i : 97 + i;
    foreach (digit_codes[i])  if (digit_codes[i] == c)  r = sh ? int'(shifted_digits[i]) : 48 + i;
    if (c == 8'h29) r = 32;
    if (c == 8'h5A) r = 13;
    if (c == 8'h66) r = 8;
    return r;
  endfunction

  // Applies one consumed code to the keyboard model; returns the pushed char or -1.
  function automatic int consume(logic [7:0] c);
    int ch = -1;
    if (m_ext && m_brk) begin
      m_ext = 0;
      m_brk = 0;
    end else if (m_ext) begin
      if (c == 8'hF0) m_brk = 1;
      else begin
        m_ext = 0;
        if (c == 8'h5A) ch = 13;
      end
    end else if (m_brk) begin
      m_brk = 0;
      if (c == 8'h12) m_shl = 0;
      if (c == 8'h59) m_shr = 0;
      if (c == 8'h58) m_held = 0;
    end else if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'h12) m_shl = 1;
    else if (c == 8'h59) m_shr = 1;
    else if (c == 8'h58) begin
      if (CAPS_EN && !m_held) m_caps = !m_caps;
      m_held = 1;
    end else ch = xlate(c, m_shl | m_shr, m_caps);
    return ch;
  endfunction

  task automatic step();
    bit pop_e, push_e, ovf_e;
    int ch;
    @(posedge clk); #1;
    avail        = (codes.size() != 0) && (!gap_en || $urandom_range(0, 3) != 0);
    bus.kb_empty = !avail;
    bus.key_code = avail ? codes[0] : 8'($urandom);
    bus.tx_full  = (tx_mode == 1) || (tx_mode == 2 && $urandom_range(0, 2) == 0);
    @(negedge clk);
    pop_e = (mq.size() != 0) && !bus.tx_full;
    check_val("kb_rd", bus.kb_rd, avail);
    check_val("wr_uart", bus.wr_uart, pop_e);
    if (pop_e) check_val("wr_data", bus.wr_data, mq[0]);
    check_val("fifo_count", fifo_count, mq.size());
    check_val("shift_active", shift_active, m_shl | m_shr);
    check_val("caps_lock", caps_lock, m_caps);
    ch     = avail ? consume(codes.pop_front()) : -1;
    push_e = (ch >= 0);
    ovf_e  = push_e && (mq.size() == DEPTH) && !pop_e;
    check_val("overflow", overflow, ovf_e);
    if (bus.wr_uart) got.push_back(bus.wr_data);
    if (bus.kb_rd) n_rd++;
    if (overflow) n_ovf++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (pop_e) void'(mq.pop_front());
    if (push_e && !ovf_e) mq.push_back(8'(ch));
  endtask

  task automatic run_seq(input bit gap, input int txm, input bit drain);
    int budget = 400 + 10 * seq.size();
    foreach (seq[i]) codes.push_back(seq[i]);
    gap_en = gap; tx_mode = txm;
    got.delete(); n_rd = 0; n_ovf = 0; max_cnt = 0; loop_steps = 0;
    while ((codes.size() != 0 || (drain && mq.size() != 0)) && budget > 0) begin
      step();
      budget--;
      loop_steps++;
    end
    check_val("timeout", (budget == 0), 0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    bus.kb_empty = 1'b0;
    bus.key_code = 8'h1C;
    bus.tx_full  = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_kb_rd", bus.kb_rd, 0);
    check_val("rst_wr_uart", bus.wr_uart, 0);
    check_val("rst_wr_data", bus.wr_data, 8'h00);
    check_val("rst_count", fifo_count, 0);
    check_val("rst_shift", shift_active, 0);
    check_val("rst_caps", caps_lock, 0);
    check_val("rst_overflow", overflow, 0);
    codes.delete(); mq.delete();
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.kb_empty = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    int r = $urandom_range(0, 99);
    if (r < 30) return letter_codes[$urandom_range(0, 25)];
    if (r < 45) return digit_codes[$urandom_range(0, 9)];
    if (r < 55) return 8'hF0;
    if (r < 62) return 8'hE0;
    if (r < 70) return 8'h12;
    if (r < 75) return 8'h59;
    if (r < 80) return 8'h58;
    if (r < 84) return 8'h29;
    if (r < 88) return 8'h5A;
    if (r < 91) return 8'h66;
    return 8'($urandom);
  endfunction

  initial begin
    bus.kb_empty = 1'b1;
    bus.key_code = 8'h00;
    bus.tx_full  = 1'b0;
    do_reset();

    seq = {8'h1C, 8'hF0, 8'h1C};
    run_seq(0, 0, 1);
    check_val("t1_writes", got.size(), 1);
    if (got.size() == 1) check_val("t1_char", got[0], 8'h61);
    check_val("t1_kb_rd_pulses", n_rd, 3);

    seq = {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h16};
    run_seq(0, 0, 1);
    check_val("t2_writes", got.size(), 2);
    if (got.size() == 2) begin
      check_val("t2_char0", got[0], 8'h41);
      check_val("t2_char1", got[1], 8'h31);
    end

    do_reset();
`ifdef KB_CAPS_LOCK_EN
    seq = {8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C};
    run_seq(0, 0, 1);
    check_val("caps_writes", got.size(), 2);
    if (got.size() == 2) begin
      check_val("caps_char0", got[0], 8'h41);
      check_val("caps_char1", got[1], 8'h61);
    end
    check_val("caps_on", caps_lock, 1);
    do_reset();
    seq = {8'h58, 8'h58, 8'hF0, 8'h58};
    run_seq(0, 0, 1);
    check_val("caps_typematic", caps_lock, 1);
`else
    seq = {8'h58, 8'hF0, 8'h58, 8'h1C};
    run_seq(0, 0, 1);
    check_val("nocaps_writes", got.size(), 1);
    if (got.size() == 1) check_val("nocaps_char", got[0], 8'h61);
    check_val("nocaps_caps", caps_lock, 0);
`endif

    do_reset();
    seq = {8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h75};
    run_seq(1, 0, 1);
    check_val("ext_writes", got.size(), 1);
    if (got.size() == 1) check_val("ext_char", got[0], 8'h0D);
    seq = {8'h1C, 8'hF0, 8'h1C};
    run_seq(0, 0, 1);
    check_val("ext_idle_after", got.size(), 1);
    if (got.size() == 1) check_val("ext_idle_char", got[0], 8'h61);

    do_reset();
    seq.delete();
    repeat (6) begin
      seq.push_back(8'h1C); seq.push_back(8'hF0); seq.push_back(8'h1C);
    end
    run_seq(0, 1, 0);
    check_val("ovf_max_count", max_cnt, 4);
    check_val("ovf_pulses", n_ovf, 2);
    check_val("ovf_no_writes", got.size(), 0);
    seq.delete();
    run_seq(0, 0, 1);
    check_val("drain_cycles", loop_steps, 4);
    check_val("drain_writes", got.size(), 4);
    foreach (got[i]) check_val("drain_char", got[i], 8'h61);
    check_val("drain_count", fifo_count, 0);

    do_reset();
    seq = {8'h12, 8'hF0};
    run_seq(0, 0, 1);
    check_val("pre_rst_shift", shift_active, 1);
    do_reset();
    seq = {8'h1C, 8'hF0, 8'h1C};
    run_seq(0, 0, 1);
    check_val("post_rst_writes", got.size(), 1);
    if (got.size() == 1) check_val("post_rst_char", got[0], 8'h61);

    do_reset();
    for (int r = 0; r < 4; r++) begin
      seq.delete();
      for (int k = 0; k < 150; k++) seq.push_back(rand_code());
      run_seq(1, 2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
